// File: rtl/msrh_pkg.sv
// Shared types and default sizing for the rename-stage resource controller.
package msrh_pkg;

  typedef enum logic [0:0] {
    RN_IDLE    = 1'b0,
    RN_RESTORE = 1'b1
  } rn_ctrl_state_t;

  localparam int DISP_SIZE_DEF      = 2;
  localparam int FLIST_SIZE_DEF     = 32;
  localparam int SNAP_SIZE_DEF      = 4;
  localparam int RESTORE_CYCLES_DEF = 2;

  localparam int SNAP_IDX_W  = $clog2(SNAP_SIZE_DEF);
  localparam int FLIST_CNT_W = $clog2(FLIST_SIZE_DEF + 1);
  localparam int SNAP_CNT_W  = $clog2(SNAP_SIZE_DEF + 1);

endpackage

// File: rtl/msrh_rename_credit_cnt.sv
// Free physical-register credit counter for one dispatch lane freelist.
// Pop and free in the same cycle cancel; a free into a full freelist saturates.
module msrh_rename_credit_cnt #(
  parameter int FLIST_SIZE = 32,
  parameter int CNT_W      = $clog2(FLIST_SIZE + 1)
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             pop,
  input  logic             free,
  output logic [CNT_W-1:0] count,
  output logic             nonzero
);

  localparam logic [CNT_W-1:0] FULL = CNT_W'(FLIST_SIZE);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_nxt;

  always_comb begin
    cnt_nxt = cnt_q;
    if (pop && !free) begin
      cnt_nxt = cnt_q - CNT_W'(1);
    end else if (free && !pop && (cnt_q != FULL)) begin
      cnt_nxt = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      cnt_q <= FULL;
    end else begin
      cnt_q <= cnt_nxt;
    end
  end

  // A returned RNID with no room means commit and rename disagree on ownership.
  always_ff @(posedge i_clk) begin
    if (i_reset_n && free && !pop) begin
      assert (cnt_q != FULL);
    end
  end

  assign count   = cnt_q;
  assign nonzero = (cnt_q != '0);

endmodule

// File: rtl/msrh_rename_ctrl.sv
// Rename-stage resource controller: freelist credits, branch snapshot queue and
// flush recovery sequencing. Optional stall counters under MSRH_RENAME_CTRL_PERF_EN.
module msrh_rename_ctrl
  import msrh_pkg::*;
#(
  parameter int DISP_SIZE      = DISP_SIZE_DEF,
  parameter int FLIST_SIZE     = FLIST_SIZE_DEF,
  parameter int SNAP_SIZE      = SNAP_SIZE_DEF,
  parameter int RESTORE_CYCLES = RESTORE_CYCLES_DEF
) (
  input  logic                                        i_clk,
  input  logic                                        i_reset_n,
  input  logic                                        i_disp_valid,
  input  logic [DISP_SIZE-1:0]                        i_disp_rd_alloc,
  input  logic                                        i_disp_is_br,
  output logic                                        o_disp_ready,
  output logic [DISP_SIZE-1:0]                        o_flist_pop,
  output logic                                        o_snap_load,
  output logic [$clog2(SNAP_SIZE)-1:0]                o_snap_idx,
  input  logic [DISP_SIZE-1:0]                        i_cmt_free,
  input  logic                                        i_cmt_br_done,
  input  logic                                        i_flush,
  output logic                                        o_restore,
  output logic                                        o_busy,
  output logic [DISP_SIZE*$clog2(FLIST_SIZE+1)-1:0]   o_free_cnt,
  output logic [$clog2(SNAP_SIZE+1)-1:0]              o_snap_cnt,
  output logic [31:0]                                 o_perf_stall_flist,
  output logic [31:0]                                 o_perf_stall_snap
);

  localparam int SIDX_W = $clog2(SNAP_SIZE);
  localparam int SCNT_W = $clog2(SNAP_SIZE + 1);
  localparam int CRED_W = $clog2(FLIST_SIZE + 1);
  localparam int RCNT_W = (RESTORE_CYCLES > 1) ? $clog2(RESTORE_CYCLES) : 1;

  localparam logic [RCNT_W-1:0] RCNT_LOAD = RCNT_W'(RESTORE_CYCLES - 1);
  localparam logic [SCNT_W-1:0] SNAP_FULL = SCNT_W'(SNAP_SIZE);
  localparam logic [SIDX_W-1:0] SIDX_LAST = SIDX_W'(SNAP_SIZE - 1);

  rn_ctrl_state_t       state_q;
  rn_ctrl_state_t       state_nxt;
  logic [RCNT_W-1:0]    rcnt_q;
  logic [RCNT_W-1:0]    rcnt_nxt;
  logic                 restore_q;
  logic [SIDX_W-1:0]    wr_ptr_q;
  logic [SIDX_W-1:0]    rd_ptr_q;
  logic [SCNT_W-1:0]    snap_cnt_q;
  logic [DISP_SIZE-1:0] nonzero;
  logic [DISP_SIZE-1:0] pop;
  logic                 idle;
  logic                 ready;
  logic                 credit_ok;
  logic                 snap_ok;
  logic                 accept;
  logic                 snap_load;
  logic                 br_pop;

  assign credit_ok = &(~i_disp_rd_alloc | nonzero);
  assign snap_ok   = !i_disp_is_br || (snap_cnt_q < SNAP_FULL);
  assign accept    = i_disp_valid & ready;
  assign pop       = i_disp_rd_alloc & {DISP_SIZE{accept}};
  assign snap_load = accept & i_disp_is_br;
  assign br_pop    = i_cmt_br_done & (snap_cnt_q != '0);

  for (genvar g = 0; g < DISP_SIZE; g++) begin : g_lane
    msrh_rename_credit_cnt #(
      .FLIST_SIZE (FLIST_SIZE),
      .CNT_W      (CRED_W)
    ) u_credit (
      .i_clk     (i_clk),
      .i_reset_n (i_reset_n),
      .pop       (pop[g]),
      .free      (i_cmt_free[g]),
      .count     (o_free_cnt[g*CRED_W +: CRED_W]),
      .nonzero   (nonzero[g])
    );
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q   <= RN_IDLE;
      rcnt_q    <= '0;
      restore_q <= 1'b0;
    end else begin
      state_q   <= state_nxt;
      rcnt_q    <= rcnt_nxt;
      restore_q <= i_flush;
    end
  end

  // A flush during recovery restarts the restore window from the top.
  always_comb begin
    state_nxt = state_q;
    rcnt_nxt  = rcnt_q;
    case (state_q)
      RN_IDLE: begin
        if (i_flush) begin
          state_nxt = RN_RESTORE;
          rcnt_nxt  = RCNT_LOAD;
        end
      end
      RN_RESTORE: begin
        if (i_flush) begin
          rcnt_nxt = RCNT_LOAD;
        end else if (rcnt_q == '0) begin
          state_nxt = RN_IDLE;
        end else begin
          rcnt_nxt = rcnt_q - RCNT_W'(1);
        end
      end
      default: state_nxt = RN_IDLE;
    endcase
  end

  always_comb begin
    idle   = (state_q == RN_IDLE);
    o_busy = (state_q == RN_RESTORE);
    ready  = i_reset_n & idle & ~i_flush & credit_ok & snap_ok;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      snap_cnt_q <= '0;
    end else if (i_flush) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      snap_cnt_q <= '0;
    end else begin
      if (snap_load) begin
        wr_ptr_q <= (wr_ptr_q == SIDX_LAST) ? '0 : wr_ptr_q + SIDX_W'(1);
      end
      if (br_pop) begin
        rd_ptr_q <= (rd_ptr_q == SIDX_LAST) ? '0 : rd_ptr_q + SIDX_W'(1);
      end
      case ({snap_load, br_pop})
        2'b10:   snap_cnt_q <= snap_cnt_q + SCNT_W'(1);
        2'b01:   snap_cnt_q <= snap_cnt_q - SCNT_W'(1);
        default: snap_cnt_q <= snap_cnt_q;
      endcase
    end
  end

  // Retiring a snapshot that was never taken points at a commit-side bug.
  always_ff @(posedge i_clk) begin
    if (i_reset_n && i_cmt_br_done) begin
      assert (snap_cnt_q != '0);
    end
  end

  assign o_disp_ready = ready;
  assign o_flist_pop  = pop;
  assign o_snap_load  = snap_load;
  assign o_snap_idx   = wr_ptr_q;
  assign o_snap_cnt   = snap_cnt_q;
  assign o_restore    = restore_q;

`ifdef MSRH_RENAME_CTRL_PERF_EN
  logic [31:0] stall_flist_q;
  logic [31:0] stall_snap_q;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      stall_flist_q <= '0;
      stall_snap_q  <= '0;
    end else begin
      if (i_disp_valid && !ready && idle && !credit_ok && (stall_flist_q != '1)) begin
        stall_flist_q <= stall_flist_q + 32'd1;
      end
      if (i_disp_valid && !ready && idle && !snap_ok && (stall_snap_q != '1)) begin
        stall_snap_q <= stall_snap_q + 32'd1;
      end
    end
  end

  assign o_perf_stall_flist = stall_flist_q;
  assign o_perf_stall_snap  = stall_snap_q;
`else
  assign o_perf_stall_flist = '0;
  assign o_perf_stall_snap  = '0;
`endif

endmodule

// File: tb/tb_msrh_rename_ctrl.sv
// Self-checking bench for msrh_rename_ctrl: vector table, directed corner sequences
// and randomized traffic against a queue/counter-level reference model.
module tb_msrh_rename_ctrl;
  import msrh_pkg::*;

  localparam int NL = DISP_SIZE_DEF;
  localparam int FL = FLIST_SIZE_DEF;
  localparam int SN = SNAP_SIZE_DEF;
  localparam int RC = RESTORE_CYCLES_DEF;
  localparam int CW = FLIST_CNT_W;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic v = 1'b0, br = 1'b0, bd = 1'b0, fl = 1'b0;
  logic [NL-1:0] a = '0, fr = '0;

  logic                  o_disp_ready, o_snap_load, o_restore, o_busy;
  logic [NL-1:0]         o_flist_pop;
  logic [SNAP_IDX_W-1:0] o_snap_idx;
  logic [NL*CW-1:0]      o_free_cnt;
  logic [SNAP_CNT_W-1:0] o_snap_cnt;
  logic [31:0]           o_perf_stall_flist, o_perf_stall_snap;

  always #5 clk = ~clk;

  msrh_rename_ctrl dut (
    .i_clk              (clk),
    .i_reset_n          (rst_n),
    .i_disp_valid       (v),
    .i_disp_rd_alloc    (a),
    .i_disp_is_br       (br),
    .o_disp_ready       (o_disp_ready),
    .o_flist_pop        (o_flist_pop),
    .o_snap_load        (o_snap_load),
    .o_snap_idx         (o_snap_idx),
    .i_cmt_free         (fr),
    .i_cmt_br_done      (bd),
    .i_flush            (fl),
    .o_restore          (o_restore),
    .o_busy             (o_busy),
    .o_free_cnt         (o_free_cnt),
    .o_snap_cnt         (o_snap_cnt),
    .o_perf_stall_flist (o_perf_stall_flist),
    .o_perf_stall_snap  (o_perf_stall_snap)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: credits as plain integers, snapshot queue as an occupancy
  // count plus next slot, recovery as "cycles of blocking left".
  int cred[NL];
  int scnt, widx, rest_left;
  bit rest_pulse;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int lane_cnt(input int l);
    logic [NL*CW-1:0] all;
    all = o_free_cnt;
    return int'(all[l*CW +: CW]);
  endfunction

  task automatic model_reset();
    for (int l = 0; l < NL; l++) cred[l] = FL;
    scnt = 0;
    widx = 0;
    rest_left = 0;
    rest_pulse = 0;
  endtask

  function automatic bit m_ready();
    bit r;
    r = rst_n && (rest_left == 0) && !fl && (!br || scnt < SN);
    for (int l = 0; l < NL; l++) if (a[l] && cred[l] == 0) r = 0;
    return r;
  endfunction

  task automatic model_update();
    bit acc;
    int old;
    acc = m_ready() && v;
    for (int l = 0; l < NL; l++) begin
      cred[l] = cred[l] - int'(acc && a[l]) + int'(fr[l]);
      if (cred[l] > FL) cred[l] = FL;
    end
    old = scnt;
    if (fl) begin
      scnt = 0;
      widx = 0;
    end else begin
      if (acc && br) begin
        widx = (widx + 1) % SN;
        scnt++;
      end
      if (bd && old > 0) scnt--;
    end
    rest_pulse = fl;
    if (fl) rest_left = RC;
    else if (rest_left > 0) rest_left--;
  endtask

  task automatic check_all(input string tag);
    bit r;
    r = m_ready();
    chk({tag, ".ready"}, 32'(o_disp_ready), 32'(r));
    chk({tag, ".pop"}, 32'(o_flist_pop), (r && v) ? 32'(a) : 32'd0);
    chk({tag, ".load"}, 32'(o_snap_load), 32'(r && v && br));
    chk({tag, ".idx"}, 32'(o_snap_idx), 32'(widx));
    chk({tag, ".busy"}, 32'(o_busy), 32'(rest_left > 0));
    chk({tag, ".restore"}, 32'(o_restore), 32'(rest_pulse));
    for (int l = 0; l < NL; l++) chk({tag, ".cred"}, 32'(lane_cnt(l)), 32'(cred[l]));
    chk({tag, ".scnt"}, 32'(o_snap_cnt), 32'(scnt));
  endtask

  // Called just after a falling edge: drive, settle, compare against the model.
  task automatic apply(input logic iv, input logic [NL-1:0] ia, input logic ibr,
                       input logic [NL-1:0] ifr, input logic ibd, input logic ifl,
                       input string tag);
    v = iv; a = ia; br = ibr; fr = ifr; bd = ibd; fl = ifl;
    #1;
    check_all(tag);
  endtask

  task automatic advance();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    v = 0; a = '0; br = 0; fr = '0; bd = 0; fl = 0;
    #1;
    chk("rst.ready", 32'(o_disp_ready), 0);
    chk("rst.busy", 32'(o_busy), 0);
    chk("rst.restore", 32'(o_restore), 0);
    chk("rst.cred0", 32'(lane_cnt(0)), FL);
    chk("rst.cred1", 32'(lane_cnt(1)), FL);
    chk("rst.scnt", 32'(o_snap_cnt), 0);
    chk("rst.idx", 32'(o_snap_idx), 0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  typedef struct {
    logic       v;
    logic [1:0] a;
    logic       br;
    logic       fl;
    logic       e_ready;
    logic [1:0] e_pop;
    logic       e_load;
    int         e_idx;
    logic       e_busy;
    logic       e_restore;
    int         e_c0;
    int         e_c1;
    int         e_scnt;
  } vec_t;

  vec_t tbl[8];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{1'b1, 2'b11, 1'b0, 1'b0, 1'b1, 2'b11, 1'b0, 0, 1'b0, 1'b0, 32, 32, 0};
    tbl[1] = '{1'b1, 2'b01, 1'b1, 1'b0, 1'b1, 2'b01, 1'b1, 0, 1'b0, 1'b0, 31, 31, 0};
    tbl[2] = '{1'b0, 2'b10, 1'b1, 1'b0, 1'b1, 2'b00, 1'b0, 1, 1'b0, 1'b0, 30, 31, 1};
    tbl[3] = '{1'b1, 2'b00, 1'b1, 1'b0, 1'b1, 2'b00, 1'b1, 1, 1'b0, 1'b0, 30, 31, 1};
    tbl[4] = '{1'b1, 2'b11, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 2, 1'b0, 1'b0, 30, 31, 2};
    tbl[5] = '{1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 0, 1'b1, 1'b1, 30, 31, 0};
    tbl[6] = '{1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 0, 1'b1, 1'b0, 30, 31, 0};
    tbl[7] = '{1'b1, 2'b10, 1'b1, 1'b0, 1'b1, 2'b10, 1'b1, 0, 1'b0, 1'b0, 30, 31, 0};

    model_reset();
    do_reset();

    for (int i = 0; i < 8; i++) begin
      apply(tbl[i].v, tbl[i].a, tbl[i].br, 2'b00, 1'b0, tbl[i].fl, "tblm");
      chk("tbl.ready", 32'(o_disp_ready), 32'(tbl[i].e_ready));
      chk("tbl.pop", 32'(o_flist_pop), 32'(tbl[i].e_pop));
      chk("tbl.load", 32'(o_snap_load), 32'(tbl[i].e_load));
      chk("tbl.idx", 32'(o_snap_idx), 32'(tbl[i].e_idx));
      chk("tbl.busy", 32'(o_busy), 32'(tbl[i].e_busy));
      chk("tbl.restore", 32'(o_restore), 32'(tbl[i].e_restore));
      chk("tbl.cred0", 32'(lane_cnt(0)), 32'(tbl[i].e_c0));
      chk("tbl.cred1", 32'(lane_cnt(1)), 32'(tbl[i].e_c1));
      chk("tbl.scnt", 32'(o_snap_cnt), 32'(tbl[i].e_scnt));
      advance();
    end

    // Credit exhaustion on lane 0
    do_reset();
    for (int i = 0; i < FL; i++) begin
      apply(1, 2'b01, 0, 2'b00, 0, 0, "exh");
      advance();
    end
    apply(1, 2'b01, 0, 2'b00, 0, 0, "exh");
    chk("exh.cred0", 32'(lane_cnt(0)), 0);
    chk("exh.ready_l0", 32'(o_disp_ready), 0);
    advance();
    apply(1, 2'b10, 0, 2'b00, 0, 0, "exh");
    chk("exh.ready_l1", 32'(o_disp_ready), 1);
    advance();
    apply(0, 2'b01, 0, 2'b01, 0, 0, "exh");
    chk("exh.nobypass", 32'(o_disp_ready), 0);
    advance();
    apply(1, 2'b01, 0, 2'b00, 0, 0, "exh");
    chk("exh.ready_back", 32'(o_disp_ready), 1);
    advance();

    // Simultaneous pop and free at credit 5
    do_reset();
    for (int i = 0; i < FL - 5; i++) begin
      apply(1, 2'b11, 0, 2'b00, 0, 0, "pf");
      advance();
    end
    apply(1, 2'b11, 0, 2'b11, 0, 0, "pf");
    chk("pf.pop", 32'(o_flist_pop), 32'b11);
    advance();
    apply(0, 2'b00, 0, 2'b00, 0, 0, "pf");
    chk("pf.cred0", 32'(lane_cnt(0)), 5);
    chk("pf.cred1", 32'(lane_cnt(1)), 5);
    advance();

    // Snapshot full and wrap
    do_reset();
    for (int i = 0; i < SN; i++) begin
      apply(1, 2'b00, 1, 2'b00, 0, 0, "snap");
      chk("snap.idx", 32'(o_snap_idx), 32'(i));
      advance();
    end
    apply(1, 2'b00, 1, 2'b00, 0, 0, "snap");
    chk("snap.full_br", 32'(o_disp_ready), 0);
    advance();
    apply(1, 2'b01, 0, 2'b00, 0, 0, "snap");
    chk("snap.full_nonbr", 32'(o_disp_ready), 1);
    advance();
    apply(0, 2'b00, 0, 2'b00, 1, 0, "snap");
    advance();
    apply(1, 2'b00, 1, 2'b00, 0, 0, "snap");
    chk("snap.wrap_ready", 32'(o_disp_ready), 1);
    chk("snap.wrap_idx", 32'(o_snap_idx), 0);
    advance();

    // Flush with three live snapshots
    do_reset();
    for (int i = 0; i < 3; i++) begin
      apply(1, 2'b00, 1, 2'b00, 0, 0, "fl");
      advance();
    end
    apply(1, 2'b01, 0, 2'b00, 0, 1, "fl");
    chk("fl.T_ready", 32'(o_disp_ready), 0);
    chk("fl.T_scnt", 32'(o_snap_cnt), 3);
    advance();
    apply(1, 2'b01, 0, 2'b00, 0, 0, "fl");
    chk("fl.T1_restore", 32'(o_restore), 1);
    chk("fl.T1_busy", 32'(o_busy), 1);
    chk("fl.T1_ready", 32'(o_disp_ready), 0);
    chk("fl.T1_scnt", 32'(o_snap_cnt), 0);
    advance();
    apply(1, 2'b01, 0, 2'b00, 0, 0, "fl");
    chk("fl.T2_busy", 32'(o_busy), 1);
    chk("fl.T2_restore", 32'(o_restore), 0);
    chk("fl.T2_ready", 32'(o_disp_ready), 0);
    advance();
    apply(1, 2'b01, 0, 2'b00, 0, 0, "fl");
    chk("fl.T3_ready", 32'(o_disp_ready), 1);
    chk("fl.T3_busy", 32'(o_busy), 0);
    advance();

    // Second flush during RESTORE
    apply(0, 2'b00, 0, 2'b00, 0, 1, "ff");
    advance();
    apply(0, 2'b00, 0, 2'b00, 0, 1, "ff");
    chk("ff.T1_restore", 32'(o_restore), 1);
    advance();
    apply(1, 2'b01, 0, 2'b00, 0, 0, "ff");
    chk("ff.T2_restore", 32'(o_restore), 1);
    chk("ff.T2_busy", 32'(o_busy), 1);
    advance();
    apply(1, 2'b01, 0, 2'b00, 0, 0, "ff");
    chk("ff.T3_busy", 32'(o_busy), 1);
    chk("ff.T3_ready", 32'(o_disp_ready), 0);
    advance();
    apply(1, 2'b01, 0, 2'b00, 0, 0, "ff");
    chk("ff.T4_busy", 32'(o_busy), 0);
    chk("ff.T4_ready", 32'(o_disp_ready), 1);
    advance();

    // Reset in the middle of RESTORE
    apply(1, 2'b11, 1, 2'b00, 0, 0, "rr");
    advance();
    apply(0, 2'b00, 0, 2'b00, 0, 1, "rr");
    advance();
    apply(0, 2'b00, 0, 2'b00, 0, 0, "rr");
    chk("rr.busy_before", 32'(o_busy), 1);
    rst_n = 1'b0;
    #1;
    chk("rr.busy", 32'(o_busy), 0);
    chk("rr.restore", 32'(o_restore), 0);
    chk("rr.ready", 32'(o_disp_ready), 0);
    chk("rr.cred0", 32'(lane_cnt(0)), FL);
    chk("rr.cred1", 32'(lane_cnt(1)), FL);
    chk("rr.scnt", 32'(o_snap_cnt), 0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    apply(0, 2'b00, 0, 2'b00, 0, 0, "rr");
    chk("rr.post_restore", 32'(o_restore), 0);
    advance();
    apply(1, 2'b11, 0, 2'b00, 0, 0, "rr");
    chk("rr.post_ready", 32'(o_disp_ready), 1);
    chk("rr.post_restore2", 32'(o_restore), 0);
    advance();

    // Randomized traffic; frees and br_done only where commit could legally issue them
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      logic [NL-1:0] rfr;
      logic rbd;
      for (int l = 0; l < NL; l++) rfr[l] = (cred[l] < FL) && ($urandom_range(3) == 0);
      rbd = (scnt > 0) && ($urandom_range(2) == 0);
      apply(1'($urandom_range(1)), NL'($urandom), 1'($urandom_range(1)), rfr, rbd,
            ($urandom_range(39) == 0), "rnd");
      advance();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
